// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the instruction prefetch queue.
package fetch_queue_pkg;

    localparam logic [31:0] FQ_NOP         = 32'h00000013;
    localparam int          FQ_ENTRY_WIDTH = 64;
    localparam logic [31:0] FQ_RESET_PC    = 32'h00000000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    // Word-align a fetch address; the low two bits carry no meaning for imem.
    function automatic logic [31:0] fq_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// fq_fifo: generic synchronous FIFO with flush, async active-high clear.
// Pointers wrap naturally (DEPTH is a power of two); count tells full from empty.
module fq_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Next-state for storage, pointers and occupancy; flush overrides push/pop.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetch in front of the IF/ID register.
// Issues one imem read per cycle while queue credit allows, buffers {pc, instr}
// pairs in fq_fifo and hands them to decode with valid/ready. A redirect flushes
// everything and restarts fetch at the new PC.
// Build option: define FETCH_BYPASS_EN to forward a response straight to decode
// when the queue is empty and decode is ready (1-cycle redirect latency).
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = FQ_RESET_PC,
    localparam int         CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic [31:0]   imemaddr,
    output logic          imemrd,
    input  logic [31:0]   imemdataout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    output logic [CW-1:0] count
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pending_q, pending_d;
    logic [31:0] last_pc_q, last_pc_d;
    logic [31:0] last_instr_q, last_instr_d;

    logic [31:0]               redirect_addr;
    logic [CW:0]               inflight;
    logic                      credit_ok;
    logic                      bypass;
    logic                      fifo_push, fifo_pop;
    logic                      fifo_full, fifo_empty;
    logic [CW-1:0]             fifo_count;
    logic [FQ_ENTRY_WIDTH-1:0] fifo_dout;
    fq_entry_t                 wr_entry, head_entry;

    assign head_entry = fifo_dout;
    assign count      = fifo_count;

    // Request issue: redirect always fetches; otherwise only with a free slot
    // for every entry already stored or in flight. The strobe is held off while
    // clr is asserted so imem sees no request during reset.
    always_comb begin
        redirect_addr = fq_align(redirect_pc);
        inflight      = {1'b0, fifo_count} + {{CW{1'b0}}, pending_q};
        credit_ok     = ~fifo_full & (inflight < (CW+1)'(DEPTH));
        imemrd        = ~clr & (redirect | credit_ok);
        imemaddr      = redirect ? redirect_addr : fetch_pc_q;
    end

    // Decode-side handshake, optional empty-queue bypass and FIFO controls.
    always_comb begin
`ifdef FETCH_BYPASS_EN
        bypass = fifo_empty & pending_q & out_ready & ~redirect;
`else
        bypass = 1'b0;
`endif
        out_valid = ~redirect & (~fifo_empty | bypass);
        if (out_valid) begin
            out_pc    = fifo_empty ? pend_pc_q   : head_entry.pc;
            out_instr = fifo_empty ? imemdataout : head_entry.instr;
        end else begin
            out_pc    = last_pc_q;
            out_instr = last_instr_q;
        end
        fifo_pop       = out_valid & out_ready & ~fifo_empty;
        fifo_push      = pending_q & ~redirect & ~bypass;
        wr_entry.pc    = pend_pc_q;
        wr_entry.instr = imemdataout;
        last_pc_d      = out_pc;
        last_instr_d   = out_instr;
    end

    // Fetch PC / in-flight tracking; redirect takes priority over sequential issue.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        pending_d  = 1'b0;
        if (redirect) begin
            fetch_pc_d = redirect_addr + 32'd4;
            pend_pc_d  = redirect_addr;
            pending_d  = 1'b1;
        end else if (imemrd) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pend_pc_d  = fetch_pc_q;
            pending_d  = 1'b1;
        end
    end

    // Control registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fetch_pc_q   <= RESET_PC;
            pend_pc_q    <= '0;
            pending_q    <= 1'b0;
            last_pc_q    <= '0;
            last_instr_q <= FQ_NOP;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pend_pc_q    <= pend_pc_d;
            pending_q    <= pending_d;
            last_pc_q    <= last_pc_d;
            last_instr_q <= last_instr_d;
        end
    end

    fq_fifo #(
        .WIDTH(FQ_ENTRY_WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .clr  (clr),
        .push (fifo_push),
        .pop  (fifo_pop),
        .flush(redirect),
        .din  (wr_entry),
        .dout (fifo_dout),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model compared every negedge,
// plus directed literal checks for latency, credit, redirect, clr and wrap.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] KEY = 32'hA5A5A5A5;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          out_ready = 1'b0;
    logic [31:0]   imemdataout = 32'hDEADBEEF;
    logic [31:0]   imemaddr;
    logic          imemrd;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic [CW-1:0] count;

    int checks   = 0;
    int failures = 0;
    int req_cnt  = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .clr        (clr),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imemaddr   (imemaddr),
        .imemrd     (imemrd),
        .imemdataout(imemdataout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .count      (count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_fetch = 32'h0;
    logic [31:0] m_pend_pc = 32'h0;
    bit          m_pend = 1'b0;
    logic [31:0] m_last_pc = 32'h0;
    logic [31:0] m_last_instr = NOP;
    logic [31:0] acc_log[$];

    function automatic void model_expect(output bit rd, output logic [31:0] addr,
                                         output bit vld, output logic [31:0] pc,
                                         output logic [31:0] ins, output bit byp);
        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = (mq.size() == 0) && m_pend && out_ready && !redirect && !clr;
`endif
        rd   = !clr && (redirect || (mq.size() + int'(m_pend) < DEPTH));
        addr = redirect ? (redirect_pc & 32'hFFFFFFFC) : m_fetch;
        vld  = !redirect && (mq.size() != 0 || byp);
        if (mq.size() != 0) begin
            pc = mq[0].pc; ins = mq[0].instr;
        end else if (byp) begin
            pc = m_pend_pc; ins = imemdataout;
        end else begin
            pc = m_last_pc; ins = m_last_instr;
        end
    endfunction

    // Model state update plus the 1-cycle-latency imem (data = addr ^ KEY).
    always @(posedge clk or posedge clr) begin
        bit e_rd, e_vld, e_byp;
        logic [31:0] e_addr, e_pc, e_ins;
        if (clr) begin
            mq.delete();
            m_fetch = 32'h0; m_pend = 1'b0; m_pend_pc = 32'h0;
            m_last_pc = 32'h0; m_last_instr = NOP;
            imemdataout <= 32'hDEADBEEF;
        end else begin
            model_expect(e_rd, e_addr, e_vld, e_pc, e_ins, e_byp);
            imemdataout <= e_rd ? (e_addr ^ KEY) : 32'hDEADBEEF;
            if (redirect) begin
                mq.delete();
                m_pend = 1'b1; m_pend_pc = e_addr; m_fetch = e_addr + 32'd4;
            end else begin
                if (e_vld) begin m_last_pc = e_pc; m_last_instr = e_ins; end
                if (e_vld && out_ready && mq.size() != 0) void'(mq.pop_front());
                if (m_pend && !e_byp) begin
                    if (mq.size() >= DEPTH) begin
                        failures++;
                        $display("FAIL model_overflow actual=%0d required<%0d", mq.size(), DEPTH);
                    end
                    mq.push_back('{pc: m_pend_pc, instr: imemdataout});
                end
                if (e_rd) begin m_pend_pc = m_fetch; m_fetch = m_fetch + 32'd4; m_pend = 1'b1; end
                else m_pend = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit e_rd, e_vld, e_byp;
        logic [31:0] e_addr, e_pc, e_ins;
        model_expect(e_rd, e_addr, e_vld, e_pc, e_ins, e_byp);
        check("cyc_imemrd", imemrd, e_rd);
        check("cyc_imemaddr", imemaddr, e_addr);
        check("cyc_out_valid", out_valid, e_vld);
        check("cyc_count", count, mq.size());
        if (e_vld || mq.size() == 0) begin
            check("cyc_out_pc", out_pc, e_pc);
            check("cyc_out_instr", out_instr, e_ins);
        end
        if (imemrd === 1'b1) req_cnt++;
        if (out_valid === 1'b1 && out_ready) acc_log.push_back(out_pc);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic check_log(input string name, input int idx, input logic [31:0] exp);
        check(name, (idx < acc_log.size()) ? acc_log[idx] : 32'hxxxxxxxx, exp);
    endtask

    initial begin
        bit bad;

        // T1: reset values, then streaming with decode always ready
        clr = 1'b1; out_ready = 1'b1;
        step(); step();
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_pc", out_pc, 0);
        check("rst_instr", out_instr, NOP);
        check("rst_imemrd", imemrd, 0);
        clr = 1'b0; #1;
        check("t1_first_rd", imemrd, 1);
        check("t1_first_addr", imemaddr, 32'h0);
        check("t1_valid_a", out_valid, 0);
        step();
        check("t1_addr_4", imemaddr, 32'h4);
        check("t1_valid_a1", out_valid, BYP);
        if (!BYP) step();
        check("t1_head_valid", out_valid, 1);
        check("t1_head_pc", out_pc, 32'h0);
        check("t1_head_instr", out_instr, 32'hA5A5A5A5);
        step();
        check("t1_next_pc", out_pc, 32'h4);
        check("t1_next_instr", out_instr, 32'hA5A5A5A1);
        run(4);

        // T2: decode stalled from reset fills exactly DEPTH entries
        clr = 1'b1; step();
        clr = 1'b0; out_ready = 1'b0; req_cnt = 0;
        run(5);
        check("t2_count_full", count, 4);
        check("t2_no_issue", imemrd, 0);
        check("t2_req_cnt", req_cnt, 4);
        check("t2_head_pc", out_pc, 32'h0);
        acc_log.delete();
        out_ready = 1'b1; #1;
        check("t2_no_credit_on_pop", imemrd, 0);
        step();
        check("t2_resume_rd", imemrd, 1);
        check("t2_resume_addr", imemaddr, 32'h10);
        run(6);
        check_log("t2_pop0", 0, 32'h0);
        check_log("t2_pop1", 1, 32'h4);
        check_log("t2_pop2", 2, 32'h8);
        check_log("t2_pop3", 3, 32'hC);
        check_log("t2_pop4", 4, 32'h10);

        // T3: redirect while count=3 and a request is in flight
        clr = 1'b1; step();
        clr = 1'b0; out_ready = 1'b0;
        run(4);
        check("t3_pre_count", count, 3);
        redirect = 1'b1; redirect_pc = 32'h00000102; acc_log.delete(); #1;
        check("t3_redir_addr", imemaddr, 32'h100);
        check("t3_redir_rd", imemrd, 1);
        check("t3_redir_valid", out_valid, 0);
        step();
        redirect = 1'b0; out_ready = 1'b1; #1;
        check("t3_post_count", count, 0);
        check("t3_post_valid", out_valid, BYP);
        run(6);
        check_log("t3_first_pc", 0, 32'h100);
        check_log("t3_second_pc", 1, 32'h104);
        bad = 1'b0;
        foreach (acc_log[i]) if (acc_log[i] < 32'h100) bad = 1'b1;
        check("t3_no_stale", bad, 0);

        // T3b: redirect-to-decode latency from a flowing stream
        redirect = 1'b1; redirect_pc = 32'h40; step();
        redirect = 1'b0; #1;
        check("t3b_valid_r1", out_valid, BYP);
        check("t3b_count_r1", count, 0);
`ifdef FETCH_BYPASS_EN
        check("t3b_pc_r1", out_pc, 32'h40);
`else
        step();
        check("t3b_valid_r2", out_valid, 1);
        check("t3b_pc_r2", out_pc, 32'h40);
`endif
        run(3);

        // T4: back-to-back redirects, last one wins
        redirect = 1'b1; redirect_pc = 32'h200; acc_log.delete(); step();
        redirect_pc = 32'h300; step();
        redirect = 1'b0;
        run(3);
        check_log("t4_first_pc", 0, 32'h300);
        check_log("t4_second_pc", 1, 32'h304);
        bad = 1'b0;
        foreach (acc_log[i]) if (acc_log[i] >= 32'h200 && acc_log[i] < 32'h300) bad = 1'b1;
        check("t4_no_first_epoch", bad, 0);

        // T5: async clr with two entries queued
        clr = 1'b1; step();
        clr = 1'b0; out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h500; step();
        redirect = 1'b0;
        run(2);
        check("t5_pre_count", count, 2);
        check("t5_pre_pc", out_pc, 32'h500);
        check("t5_pre_instr", out_instr, 32'hA5A5A0A5);
        clr = 1'b1; #1;
        check("t5_clr_count", count, 0);
        check("t5_clr_valid", out_valid, 0);
        check("t5_clr_pc", out_pc, 32'h0);
        check("t5_clr_instr", out_instr, NOP);
        check("t5_clr_rd", imemrd, 0);
        step();
        clr = 1'b0; out_ready = 1'b1; acc_log.delete(); #1;
        check("t5_restart_addr", imemaddr, 32'h0);
        check("t5_restart_rd", imemrd, 1);
        run(4);
        check_log("t5_first_pc", 0, 32'h0);

        // T6: fetch PC wraps modulo 2^32
        redirect = 1'b1; redirect_pc = 32'hFFFFFFF8; acc_log.delete(); step();
        redirect = 1'b0;
        run(5);
        check_log("t6_pc0", 0, 32'hFFFFFFF8);
        check_log("t6_pc1", 1, 32'hFFFFFFFC);
        check_log("t6_pc2", 2, 32'h00000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch unit between instruction memory and the IF/ID pipeline register.
- Generates sequential fetch addresses and issues one request per cycle to the synchronous imem, which has 1-cycle read latency.
- Buffers {pc, instr} pairs in a DEPTH-entry FIFO and presents them to decode with a valid/ready handshake.
- Flushes and refetches from a new PC on redirect (taken branch, jump or interrupt vector).

Parameters:
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- RESET_PC, 32'h00000000: first fetch address after reset.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- clr  in  1  reset, asynchronous, active-high.
- redirect  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored (forced to 0).
- imemaddr  out  32  fetch address; the word is returned on imemdataout in the next cycle.
- imemrd  out  1  read request strobe for imemaddr.
- imemdataout  in  32  instruction word for the request issued in the previous cycle.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head (0 = pipeline pause).
- out_pc  out  32  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (async, clr=1):
  - FIFO empty; count=0; out_valid=0; out_pc=0; out_instr=32'h00000013 (NOP).
  - fetch_pc=RESET_PC; pending=0; imemrd=0.
  - Reset mid-operation discards all entries and any in-flight response.
- Internal state:
  - fetch_pc: address of the next sequential request.
  - pending: 1 when a request was issued last cycle.
  - pend_pc: PC of that request.
- Issue rule, no redirect:
  - imemrd=1 iff count + pending < DEPTH. This is conservative: a same-cycle pop is not credited.
  - imemaddr=fetch_pc. On issue: fetch_pc += 4; pending<=1; pend_pc<=fetch_pc. Otherwise pending<=0.
- Response: when pending=1, {pend_pc, imemdataout} is pushed that cycle. The credit rule guarantees space, so no push is ever lost.
- Pop: when out_valid & out_ready, the head advances. Push and pop in the same cycle leave count unchanged.
- Full: count==DEPTH, so imemrd=0. Empty: out_valid=0, out_pc/out_instr hold their last values.
- Wrap-around: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count disambiguates full from empty.
- fetch_pc wraps modulo 2^32 (32'hFFFFFFFC+4 = 0) with no special handling.
- Redirect cycle (highest priority):
  - out_valid forced to 0 that cycle, so no pop occurs.
  - The FIFO is cleared and any response arriving this cycle is dropped.
  - imemrd=1 and imemaddr={redirect_pc[31:2],2'b00}.
  - fetch_pc <= that value + 4; pending<=1; pend_pc<=that value.
- Redirect latency: the redirected instruction is in the queue and out_valid=1 two cycles after redirect is sampled (no-bypass build).
- Back-to-back redirects: the last one wins. Each drops the previous cycle's response.
- Ordering: the queue never holds entries from two different redirect epochs.

Optional Feature:
- FETCH_BYPASS_EN defined:
  - When the FIFO is empty, a response is arriving and out_ready=1, the response is driven combinationally on out_valid/out_pc/out_instr and consumed without being written.
  - Redirect-to-decode latency becomes 1 cycle.
  - If out_ready=0, the response is written normally.
- FETCH_BYPASS_EN undefined: every instruction passes through FIFO storage; min latency is 2 cycles.

Decomposition:
- define.v gains:
  - `FQ_NOP (32'h00000013)
  - `FQ_ENTRY_WIDTH (64: pc + instr)
  - `FQ_RESET_PC default
- Sub-module fq_fifo:
  - Generic synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - Async clr.
- fetch_queue holds the fetch/credit/redirect control.

Test Plan:
- Reset release, out_ready=1, imem returns addr^32'hA5A5A5A5 -> imemaddr 0,4,8,... on consecutive cycles; out_pc=0 with out_instr=32'hA5A5A5A5 appears 2 cycles after the first imemrd; then one per cycle.
- Hold out_ready=0 from reset, DEPTH=4 -> exactly 4 requests (0..C), then imemrd=0 and count=4. Release -> entries 0,4,8,C pop in order, then fetch resumes at 32'h10.
- Redirect to 32'h00000102 while count=3 and pending=1 -> count=0 and out_valid=0 next cycle; imemaddr=32'h100 in the redirect cycle; first output out_pc=32'h100; no stale pc (e.g. 32'h0C) ever appears.
- Redirect on two consecutive cycles (32'h200, then 32'h300) -> only 32'h300, 32'h304 are output.
- Assert clr mid-stream with count=2 -> outputs at reset values immediately (async); fetch restarts at RESET_PC after release.
- With FETCH_BYPASS_EN: redirect to 32'h40 with out_ready=1 -> out_valid=1 and out_pc=32'h40 in the cycle after redirect; count stays 0.
